// File: rtl/tt_capture.sv
// Truth-table extractor: presents a = 0 .. 2^N-1 over a valid/ready probe
// handshake and packs each of the M sampled output bits into a 2^N-bit index.
module tt_capture #(
    parameter int N       = 3,
    parameter int M       = 1,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [N-1:0]        probe_a,
    output logic                probe_valid,
    input  logic [M-1:0]        resp,
    input  logic                resp_valid,
    output logic [M*(1<<N)-1:0] tt,
    output logic                tt_valid,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int DEPTH = 1 << N;
    localparam int CW    = $clog2(TIMEOUT + 1);
    localparam logic [N-1:0]  LAST_A = '1;
    localparam logic [CW-1:0] WAIT_TC = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [DEPTH-1:0] rows [M];
    logic            clear;
    logic            capture;

    assign clear   = (state == S_IDLE) && start;
    assign capture = (state == S_PROBE) && probe_valid && resp_valid;

    // One table row per output bit; probe_a indexes the row at its exact width.
    for (genvar j = 0; j < M; j++) begin : g_row
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rows[j] <= '0;
            end else if (clear) begin
                rows[j] <= '0;
            end else if (capture) begin
                rows[j][probe_a] <= resp[j];
            end
        end
        assign tt[j*DEPTH +: DEPTH] = rows[j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            probe_a     <= '0;
            probe_valid <= 1'b0;
            tt_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tt_valid    <= 1'b0;
                        err         <= 1'b0;
                        probe_a     <= '0;
                        wait_cnt    <= '0;
                        probe_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (resp_valid) begin
                        wait_cnt <= '0;
                        if (probe_a == LAST_A) begin
                            probe_valid <= 1'b0;
                            tt_valid    <= 1'b1;
                            done        <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            probe_a <= probe_a + 1'b1;
                        end
                    end else if (wait_cnt == WAIT_TC) begin
                        // This cycle is the TIMEOUT-th consecutive miss.
                        wait_cnt    <= '0;
                        err         <= 1'b1;
                        probe_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state       <= S_IDLE;
                    probe_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
